// File: rtl/if_network_controller.sv
// Run sequencer for the recurrent integrate-and-fire network.
// Ports: clk/rst (async, active-low); start/num_steps/input_spikes run command;
//   busy/done/start_err status; spike_counts/winner results; host_* weight
//   access; host_err; net_* drive and observe the network and its weight port.
module if_network_controller #(
    parameter int NUM_INPUTS       = 4,
    parameter int NUM_OUTPUTS      = 1,
    parameter int WEIGHT_SIZE      = 32,
    parameter int LAYER_ADDR_WIDTH = 32,
    parameter int STEP_WIDTH       = 16,
    parameter int COUNT_WIDTH      = 16,
    parameter int CLEAR_CYCLES     = 2,
    parameter int DRAIN_CYCLES     = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [STEP_WIDTH-1:0]                     num_steps,
    input  logic [NUM_INPUTS-1:0]                     input_spikes,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      start_err,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0]        spike_counts,
    output logic [((NUM_OUTPUTS>1)?$clog2(NUM_OUTPUTS):1)-1:0] winner,
    input  logic [LAYER_ADDR_WIDTH-1:0]               host_addr,
    input  logic [WEIGHT_SIZE-1:0]                    host_din,
    input  logic                                      host_wen,
    output logic [WEIGHT_SIZE-1:0]                    host_dout,
    output logic                                      host_err,
    output logic                                      net_rst,
    output logic [NUM_INPUTS-1:0]                     net_spike_in,
    input  logic [NUM_OUTPUTS-1:0]                    net_spike_out,
    output logic [LAYER_ADDR_WIDTH-1:0]               net_mem_addr,
    output logic [WEIGHT_SIZE-1:0]                    net_mem_din,
    output logic                                      net_mem_wen,
    input  logic [WEIGHT_SIZE-1:0]                    net_mem_dout
);

    localparam int WINW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_ARGMAX, S_DONE
    } state_t;

    state_t                  r_state;
    logic [31:0]             r_cnt;
    logic [STEP_WIDTH-1:0]   r_steps;
    logic [NUM_INPUTS-1:0]   r_pattern;
    logic [NUM_INPUTS-1:0]   r_spike_in;
    logic                    r_net_rst;
    logic                    r_done;
    logic                    r_start_err;
    logic                    r_host_err;
    logic [WINW-1:0]         r_winner;
    logic [COUNT_WIDTH-1:0]  r_best;
    logic [COUNT_WIDTH-1:0]  r_cnts [NUM_OUTPUTS];

    logic                    w_accept;
    logic                    w_clear;
    logic                    w_counting;
    logic [COUNT_WIDTH-1:0]  w_cand;

    assign w_accept   = (r_state == S_IDLE) && start && (num_steps != '0);
    assign w_clear    = w_accept || (r_state == S_CLEAR);
    assign w_counting = (r_state == S_RUN) || (r_state == S_DRAIN);

    // Count currently under inspection by the argmax scan (index = r_cnt).
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (r_cnt == 32'(i)) w_cand = r_cnts[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) r_cnts[i] <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) r_cnts[i] <= '0;
        end else if (w_counting) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                // Saturate at all-ones instead of wrapping.
                if (net_spike_out[i] && (r_cnts[i] != '1))
                    r_cnts[i] <= r_cnts[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_steps     <= '0;
            r_pattern   <= '0;
            r_spike_in  <= '0;
            r_net_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_host_err  <= 1'b0;
            r_winner    <= '0;
            r_best      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_host_err  <= host_wen && (r_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    r_net_rst <= 1'b0;
                    if (start) begin
                        if (num_steps != '0) begin
                            r_pattern <= input_spikes;
                            r_steps   <= num_steps;
                            r_cnt     <= 32'(CLEAR_CYCLES - 1);
                            r_net_rst <= 1'b1;
                            r_winner  <= '0;
                            r_state   <= S_CLEAR;
                        end else begin
                            r_start_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_winner <= '0;
                    if (r_cnt == '0) begin
                        r_net_rst  <= 1'b0;
                        r_spike_in <= r_pattern;
                        r_cnt      <= 32'(r_steps) - 32'd1;
                        r_state    <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_spike_in <= '0;
                        if (DRAIN_CYCLES > 0) begin
                            r_cnt   <= 32'(DRAIN_CYCLES - 1);
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_ARGMAX;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_ARGMAX;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_ARGMAX: begin
                    // Strictly-greater replacement keeps ties on the lowest index.
                    if ((r_cnt == '0) || (w_cand > r_best)) begin
                        r_best   <= w_cand;
                        r_winner <= r_cnt[WINW-1:0];
                    end
                    if (r_cnt == 32'(NUM_OUTPUTS - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
        assign spike_counts[g*COUNT_WIDTH +: COUNT_WIDTH] = r_cnts[g];
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign start_err    = r_start_err;
    assign host_err     = r_host_err;
    assign winner       = r_winner;
    assign net_rst      = r_net_rst;
    assign net_spike_in = r_spike_in;

    assign net_mem_addr = host_addr;
    assign net_mem_din  = host_din;
    assign net_mem_wen  = host_wen && (r_state == S_IDLE);
    assign host_dout    = net_mem_dout;

endmodule

// File: tb/tb_if_network_controller.sv
// Bench for if_network_controller: directed table, random runs against a
// timeline-based spike-count model, and hand sequences for error/reset cases.
module tb_if_network_controller;

    localparam int C  = 2;
    localparam int D  = 1;
    localparam int NO = 3;
    localparam int CWD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_steps = '0;
    logic [3:0]  input_spikes = '0;
    logic        busy, done, start_err, host_err, net_rst;
    logic [11:0] spike_counts;
    logic [1:0]  winner;
    logic [31:0] host_addr = '0;
    logic [31:0] host_din = '0;
    logic        host_wen = 1'b0;
    logic [31:0] host_dout;
    logic [3:0]  net_spike_in;
    logic [2:0]  net_spike_out = '0;
    logic [31:0] net_mem_addr, net_mem_din, net_mem_dout;
    logic        net_mem_wen;

    logic [31:0] mem [16];
    logic [2:0]  drv [64];
    int          exp_cnt [3];
    int          exp_win;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (net_mem_wen) mem[net_mem_addr[3:0]] <= net_mem_din;
    assign net_mem_dout = mem[net_mem_addr[3:0]];

    if_network_controller #(
        .NUM_INPUTS(4), .NUM_OUTPUTS(NO), .WEIGHT_SIZE(32),
        .LAYER_ADDR_WIDTH(32), .STEP_WIDTH(16), .COUNT_WIDTH(CWD),
        .CLEAR_CYCLES(C), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .input_spikes(input_spikes), .busy(busy), .done(done),
        .start_err(start_err), .spike_counts(spike_counts), .winner(winner),
        .host_addr(host_addr), .host_din(host_din), .host_wen(host_wen),
        .host_dout(host_dout), .host_err(host_err), .net_rst(net_rst),
        .net_spike_in(net_spike_in), .net_spike_out(net_spike_out),
        .net_mem_addr(net_mem_addr), .net_mem_din(net_mem_din),
        .net_mem_wen(net_mem_wen), .net_mem_dout(net_mem_dout)
    );

    typedef struct {
        int        steps;
        logic [3:0] pat;
        int        mode;
        int        c0, c1, c2;
        int        win;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Network stand-in: spike pattern on cycle k after the start edge.
    function automatic logic [2:0] gen(input int mode, input int k);
        logic [2:0] v;
        case (mode)
            1: v = {(k % 2 == 1), 1'b1, 1'b0};
            2: v = 3'b101;
            3: v = {1'b1, 1'b0, (k != C + 1)};
            4: v = 3'b111;
            default: v = 3'($urandom_range(0, 7));
        endcase
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after done.
    task automatic run(input int n, input logic [3:0] pat, input int mode);
        int k, done_k, bound, rst_bad, in_bad, busy_bad, s;
        logic [3:0] e_in;
        start = 1'b1; num_steps = 16'(n); input_spikes = pat;
        @(posedge clk); #1 start = 1'b0;
        k = 1; done_k = -1; bound = n + C + D + NO + 10;
        rst_bad = 0; in_bad = 0; busy_bad = 0;
        while (k <= bound && done_k < 0) begin
            drv[k] = gen(mode, k);
            net_spike_out = drv[k];
            @(negedge clk);
            e_in = (k > C && k <= C + n) ? pat : 4'b0;
            if (net_rst !== (k <= C)) rst_bad++;
            if (net_spike_in !== e_in) in_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) done_k = k;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        net_spike_out = '0;
        chk("done_cycle", 64'(done_k), 64'(C + n + D + NO + 1));
        chk("net_rst_window", 64'(rst_bad), 64'd0);
        chk("spike_in_window", 64'(in_bad), 64'd0);
        chk("busy_window", 64'(busy_bad), 64'd0);
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int kk = C + 1; kk <= C + n + D; kk++) s += int'(drv[kk][i]);
            exp_cnt[i] = (s > 15) ? 15 : s;
        end
        exp_win = 0;
        for (int i = 1; i < 3; i++) if (exp_cnt[i] > exp_cnt[exp_win]) exp_win = i;
        if (done_k > 0) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("count%0d", i), 64'(spike_counts[i*CWD +: CWD]), 64'(exp_cnt[i]));
            chk("winner", 64'(winner), 64'(exp_win));
        end
        @(negedge clk);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int n, dn;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i);
        tbl[0] = '{10, 4'b1010, 1, 0, 11, 6, 1};
        tbl[1] = '{6,  4'b0011, 2, 7, 0, 7, 0};
        tbl[2] = '{7,  4'b0101, 3, 7, 0, 8, 2};
        tbl[3] = '{20, 4'b1111, 4, 15, 15, 15, 0};
        tbl[4] = '{1,  4'b1001, 4, 2, 2, 2, 0};

        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_net_rst", 64'(net_rst), 64'd1);
        chk("rst_counts", 64'(spike_counts), 64'd0);
        chk("rst_winner", 64'(winner), 64'd0);
        chk("rst_spike_in", 64'(net_spike_in), 64'd0);
        chk("rst_errs", {62'd0, start_err, host_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("net_rst_release", 64'(net_rst), 64'd0);

        for (int t = 0; t < 5; t++) begin
            run(tbl[t].steps, tbl[t].pat, tbl[t].mode);
            chk($sformatf("tbl%0d_c0", t), 64'(spike_counts[3:0]), 64'(tbl[t].c0));
            chk($sformatf("tbl%0d_c1", t), 64'(spike_counts[7:4]), 64'(tbl[t].c1));
            chk($sformatf("tbl%0d_c2", t), 64'(spike_counts[11:8]), 64'(tbl[t].c2));
            chk($sformatf("tbl%0d_win", t), 64'(winner), 64'(tbl[t].win));
        end

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            run(n, 4'($urandom_range(0, 15)), 0);
        end

        // Zero-step start is rejected.
        start = 1'b1; num_steps = '0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_err_pulse", 64'(start_err), 64'd1);
        chk("start_err_busy", 64'(busy), 64'd0);
        chk("start_err_net_rst", 64'(net_rst), 64'd0);
        for (int i = 0; i < 3; i++)
            chk("start_err_counts", 64'(spike_counts[i*CWD +: CWD]), 64'(exp_cnt[i]));
        @(negedge clk);
        chk("start_err_once", 64'(start_err), 64'd0);

        // Host write blocked during a run, then allowed in idle.
        start = 1'b1; num_steps = 16'd10; input_spikes = 4'b0110;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 host_addr = 32'd5; host_din = 32'hDEAD_BEEF; host_wen = 1'b1;
        #1;
        chk("run_mem_wen", 64'(net_mem_wen), 64'd0);
        chk("mem_addr_pass", 64'(net_mem_addr), 64'd5);
        chk("mem_din_pass", 64'(net_mem_din), 64'hDEAD_BEEF);
        @(posedge clk); #1 host_wen = 1'b0;
        chk("host_err_pulse", 64'(host_err), 64'd1);
        chk("run_write_blocked", 64'(host_dout), 64'd5);
        dn = 0;
        for (int c = 0; c < 40 && dn == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn = 1;
        end
        chk("host_run_done", 64'(dn), 64'd1);
        @(negedge clk);
        host_addr = 32'd5; host_din = 32'hCAFE_F00D; host_wen = 1'b1;
        #1;
        chk("idle_mem_wen", 64'(net_mem_wen), 64'd1);
        @(posedge clk); #1 host_wen = 1'b0;
        chk("idle_host_err", 64'(host_err), 64'd0);
        chk("readback", 64'(host_dout), 64'hCAFE_F00D);

        // Reset during the third RUN cycle.
        @(negedge clk);
        start = 1'b1; num_steps = 16'd10; input_spikes = 4'b1111;
        net_spike_out = 3'b111;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_net_rst", 64'(net_rst), 64'd1);
        chk("mid_rst_counts", 64'(spike_counts), 64'd0);
        chk("mid_rst_winner", 64'(winner), 64'd0);
        chk("mid_rst_spike_in", 64'(net_spike_in), 64'd0);
        net_spike_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        chk("mid_rst_no_done", 64'(dn), 64'd0);
        run(tbl[0].steps, tbl[0].pat, tbl[0].mode);
        chk("post_rst_win", 64'(winner), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_network_controller.md
# if_network_controller

Run sequencer for the recurrent integrate-and-fire network. It accepts a start command with an input spike pattern and a timestep count, clears the network, then drives the pattern for that many cycles. It counts output spikes per output neuron and reports saturating counts plus the winning neuron. It also owns the network's weight-memory port: host accesses pass through only while the controller is idle.

## Interface
Parameters:
- NUM_INPUTS, 4, width of input spike vector
- NUM_OUTPUTS, 1, number of network output neurons (≥1)
- WEIGHT_SIZE, 32, weight data width
- LAYER_ADDR_WIDTH, 32, weight memory address width
- STEP_WIDTH, 16, width of num_steps
- COUNT_WIDTH, 16, per-output spike counter width
- CLEAR_CYCLES, 2, cycles net_rst is held at run start (≥1)
- DRAIN_CYCLES, 1, cycles counting continues after inputs stop (≥0)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE
- num_steps  in  STEP_WIDTH  timesteps to drive; sampled with start
- input_spikes  in  NUM_INPUTS  spike pattern; latched with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at run completion
- start_err  out  1  one-cycle pulse when start is rejected
- spike_counts  out  NUM_OUTPUTS*COUNT_WIDTH  per-output counts; output i is at bits [i*COUNT_WIDTH +: COUNT_WIDTH]
- winner  out  $clog2(NUM_OUTPUTS) (min 1)  index of the largest count
- host_addr / host_din / host_wen / host_dout  in / in / in / out  LAYER_ADDR_WIDTH / WEIGHT_SIZE / 1 / WEIGHT_SIZE  host weight access
- host_err  out  1  one-cycle pulse when host_wen is high and state ≠ IDLE
- net_rst  out  1  active-high clear to the network
- net_spike_in  out  NUM_INPUTS  network spike input
- net_spike_out  in  NUM_OUTPUTS  network spike output
- net_mem_addr / net_mem_din / net_mem_wen / net_mem_dout  out / out / out / in  network weight port

## Operation
- States: IDLE → CLEAR → RUN → DRAIN → ARGMAX → DONE → IDLE.
- IDLE, start=1, num_steps≠0:
  - latch input_spikes and num_steps
  - go to CLEAR
- IDLE, start=1, num_steps=0: pulse start_err and stay in IDLE.
- start outside IDLE is ignored; no error is flagged.
- CLEAR, for CLEAR_CYCLES cycles:
  - net_rst=1
  - zero all spike_counts
  - zero winner
- RUN, for exactly num_steps cycles: net_spike_in = latched pattern. In every other state net_spike_in = 0.
- DRAIN, for DRAIN_CYCLES cycles (skipped if 0): inputs are 0 and counting continues.
- Counting in RUN and DRAIN: each cycle, count i += net_spike_out[i]. Counts saturate at all-ones and never wrap.
- ARGMAX, one output per cycle for NUM_OUTPUTS cycles:
  - sequential scan from index 0
  - a candidate replaces the best only if it is strictly greater, so ties go to the lowest index
- DONE: done=1 for one cycle, then IDLE. spike_counts and winner hold until the next CLEAR.
- Memory port:
  - net_mem_addr = host_addr and net_mem_din = host_din, combinationally
  - net_mem_wen = host_wen & (state==IDLE)
  - host_dout = net_mem_dout, combinationally
  - reads are permitted in any state

## Timing
- Reset values:
  - state IDLE; busy, done, start_err, host_err = 0
  - net_rst = 1, which deasserts on the first clock edge after rst goes high
  - net_spike_in = 0, spike_counts = 0, winner = 0
- Start accepted at edge T:
  - CLEAR occupies T+1 … T+CLEAR_CYCLES
  - RUN occupies the next N cycles
  - DRAIN occupies the next D cycles
  - ARGMAX occupies the next NUM_OUTPUTS cycles
- done is high in cycle T+CLEAR_CYCLES+N+D+NUM_OUTPUTS+1; busy is high from T+1 through that cycle.
- A back-to-back start is accepted in the first IDLE cycle after DONE.
- start_err and host_err are registered and appear the cycle after the offending request.
- rst asserted mid-run:
  - immediately returns to IDLE
  - clears counts and winner
  - forces net_rst=1
  - no done pulse is produced
- A spike arriving on the last counting cycle is included. Spikes during CLEAR, ARGMAX and DONE are not counted.

## Test plan
- NUM_OUTPUTS=3, input=4'b1010, num_steps=10. The network model spikes output 1 every cycle and output 2 every other cycle. Required: counts {0, 10+D, 5 or 6}, winner=1, done at T+2+10+1+3+1.
- num_steps=0 with start=1 → start_err pulse, busy stays 0, no net_rst, counts unchanged.
- host_wen=1 during RUN → net_mem_wen=0 and host_err pulses. The same write in IDLE → net_mem_wen=1 and read-back via host_dout matches.
- COUNT_WIDTH=4, output spiking every cycle, num_steps=20 → count=15 (saturated, no wrap).
- Outputs 0 and 2 produce equal counts of 7 → winner=0. Output 2 then gets one extra spike → winner=2.
- rst pulled low at the 3rd RUN cycle → busy=0, net_rst=1, counts=0, no done. After release, a new start runs normally.
